nios_accel_spi_responder: RTL and testbench
===========================================

NIOS_ACCEL_SPI_RESPONDER -- requirements
Module: nios_accel_spi_responder

Interface
REQ-001 Parameter DEVID, default 8'hE5, read-only value returned at register address 0x00.
REQ-002 Parameter SYNC_STAGES, default 2, flop count of each input synchronizer on spi_sclk, spi_cs_n and spi_sdat_i.
REQ-003 clk_clk  input  1  sole clock; all logic rising-edge; frequency SHALL be at least 8x spi_sclk.
REQ-004 reset_reset  input  1  reset, synchronous, active-high.
REQ-005 spi_sclk  input  1  3-wire SPI clock from master, mode 3 (idle high).
REQ-006 spi_cs_n  input  1  chip select from master, active-low frame delimiter.
REQ-007 spi_sdat_i  input  1  SDIO pad input.
REQ-008 spi_sdat_o  output  1  SDIO pad drive value.
REQ-009 spi_sdat_oe  output  1  SDIO pad output enable; the top level builds the inout pad.
REQ-010 spi_int  output  1  interrupt line to the master (G_SENSOR_INT).
REQ-011 sample_x, sample_y, sample_z  input  16 each  emulated acceleration sample, two's complement.
REQ-012 sample_valid  input  1  one-cycle strobe; samples valid this cycle.

Function
REQ-013 Inputs synchronized by SYNC_STAGES flops; SCLK rise/fall and CS_N rise/fall detected on synchronized values; all references to edges below mean detected edges.
REQ-014 Register file 64 x 8: 0x00 = DEVID (read-only); 0x30 INT_SOURCE (read-only); 0x32..0x37 = X0,X1,Y0,Y1,Z0,Z1, low byte first (read-only); all other addresses read/write.
REQ-015 Frame byte 0 = command: bit7 R/W (1 = read), bit6 MB (multi-byte), bits5:0 address; bits MSB first.
REQ-016 Master data sampled on SCLK rising edge; responder read data changed on SCLK falling edge, MSB first.
REQ-017 FSM states: IDLE, CMD, WDATA, RDATA, IGNORE.
REQ-018 IDLE -> CMD on CS_N fall; CMD counts 8 rising edges, then -> RDATA if R/W=1, else WDATA.
REQ-019 RDATA: byte at current address loaded into shift register on 8th command rise; spi_sdat_oe asserts and MSB drives on the next SCLK fall; each later fall shifts one bit.
REQ-020 WDATA: 8 rising-edge bits assembled; write committed the cycle after the 8th rise; writes to read-only addresses discarded.
REQ-021 MB=1: address increments after every completed data byte, wrapping 0x3F -> 0x00; next read byte loaded at the 8th rise of the current byte.
REQ-022 MB=0: after first data byte -> IGNORE; further clocks neither write nor drive (spi_sdat_oe = 0).
REQ-023 CS_N rise in any state -> IDLE next cycle; spi_sdat_oe deasserts that cycle; partial byte discarded, no write.
REQ-024 spi_sdat_oe SHALL be 1 only in RDATA; spi_sdat_o = 0 whenever spi_sdat_oe = 0.
REQ-025 sample_valid outside a frame: 0x32..0x37 updated next cycle; INT_SOURCE bit7 (DATA_READY) set.
REQ-026 sample_valid during a frame (CS_N low): sample held pending, committed the cycle after CS_N rise; later strobes overwrite pending (latest wins).
REQ-027 DATA_READY cleared at CS_N rise ending a frame that completed a read byte from any of 0x32..0x37; a same-cycle pending commit re-sets it (set wins).
REQ-028 spi_int = |(INT_SOURCE & INT_ENABLE[0x2E]) XOR DATA_FORMAT[0x31] bit5 (INT_INVERT), registered, one cycle latency.

Reset
REQ-029 During reset_reset: FSM = IDLE, spi_sdat_o = 0, spi_sdat_oe = 0, spi_int = 0, pending cleared, all registers 0x00 except 0x00 = DEVID, synchronizers loaded with idle values (sclk 1, cs_n 1).
REQ-030 If spi_cs_n is low when reset releases, FSM enters IGNORE and accepts no command until a CS_N rise.
REQ-031 Reset asserted mid-frame aborts the frame with no write committed.

Verification
REQ-032 Single read 0x80 (addr 0x00, MB=0) -> second byte on SDIO = 8'hE5; oe low after CS_N rise.
REQ-033 Write 0x2E data 0x80, then write 0x31 data 0x00; sample_valid with x=16'h0123 -> spi_int = 1; MB read 0xF2 six bytes -> 23 01 then y, z bytes; spi_int = 0 after CS_N rise.
REQ-034 sample_valid x=16'h1111 then x=16'h2222 mid-frame during MB read of 0x32 -> frame returns old data; after CS_N rise, reread returns 22 22.
REQ-035 MB read starting 0x3F, two bytes -> reg[0x3F] then DEVID (wrap).
REQ-036 Write 0x1E, CS_N rise after 5 data bits -> reg[0x1E] unchanged; write 0x00 data 0x55 -> reads back 0xE5.
REQ-037 Reset pulsed with CS_N low mid-frame, clocks continue -> no oe, no write until CS_N rises; next frame normal.

Source files
------------

// File: rtl/nios_accel_spi_responder.sv
// nios_accel_spi_responder: 3-wire mode-3 SPI responder emulating an accelerometer register map,
// oversampling the SPI pins on clk_clk.
module nios_accel_spi_responder #(
  parameter logic [7:0] DEVID = 8'hE5,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic        spi_sclk,
  input  logic        spi_cs_n,
  input  logic        spi_sdat_i,
  output logic        spi_sdat_o,
  output logic        spi_sdat_oe,
  output logic        spi_int,
  input  logic [15:0] sample_x,
  input  logic [15:0] sample_y,
  input  logic [15:0] sample_z,
  input  logic        sample_valid
);
  typedef enum logic [2:0] {IDLE, CMD, WDATA, RDATA, IGNORE} state_t;
  state_t state_q, state_d;
  logic [SYNC_STAGES:0] sclk_q, cs_q, sdat_q, start_q;
  logic [2:0] bit_cnt_q;
  logic [6:0] rx_q;
  logic [7:0] sout_q;
  logic [5:0] addr_q, addr_nxt;
  logic mb_q, fresh_q, drive_q, rd_sample_q, pend_q, int_q;
  logic [47:0] pend_data_q, smp;
  logic [7:0] regs_q [64];
  logic [7:0] rx_byte;
  logic sclk_rise, sclk_fall, cs_rise, cs_fall, byte_done, in_frame, smp_wr;
  function automatic logic is_sample(input logic [5:0] a);
    return a >= 6'h32 && a <= 6'h37;
  endfunction
  function automatic logic writable(input logic [5:0] a);
    return a != 6'h00 && a != 6'h30 && !is_sample(a);
  endfunction
  function automatic logic [7:0] rd_reg(input logic [5:0] a);
    return a == 6'h00 ? DEVID : regs_q[a];
  endfunction
  // the top flop of each chain is the previous synchronized value, used for edge detection
  assign sclk_rise = sclk_q[SYNC_STAGES-1] & ~sclk_q[SYNC_STAGES];
  assign sclk_fall = ~sclk_q[SYNC_STAGES-1] & sclk_q[SYNC_STAGES];
  assign cs_rise = cs_q[SYNC_STAGES-1] & ~cs_q[SYNC_STAGES];
  assign cs_fall = ~cs_q[SYNC_STAGES-1] & cs_q[SYNC_STAGES];
  // data taken one flop later than sclk; the master holds it stable for several clk cycles around the rise
  assign rx_byte = {rx_q, sdat_q[SYNC_STAGES]};
  assign byte_done = sclk_rise && bit_cnt_q == 3'd7 && !cs_rise;
  assign addr_nxt = addr_q + 6'd1;
  assign in_frame = !cs_q[SYNC_STAGES-1] || state_q != IDLE;
  assign smp_wr = !in_frame && (sample_valid || pend_q);
  assign smp = sample_valid ? {sample_z, sample_y, sample_x} : pend_data_q;
  assign spi_sdat_oe = state_q == RDATA && drive_q && !cs_rise;
  assign spi_sdat_o = spi_sdat_oe & sout_q[7];
  assign spi_int = int_q;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:         if (cs_fall) state_d = start_q[0] ? IGNORE : CMD;
      CMD:          if (byte_done) state_d = rx_byte[7] ? RDATA : WDATA;
      WDATA, RDATA: if (byte_done && !mb_q) state_d = IGNORE;
      default:      state_d = state_q;
    endcase
    if (cs_rise) state_d = IDLE;
  end
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      sclk_q <= '1;
      cs_q <= '1;
      sdat_q <= '0;
      start_q <= '1;
      state_q <= IDLE;
      bit_cnt_q <= 3'd0;
      rx_q <= 7'd0;
      sout_q <= 8'd0;
      addr_q <= 6'd0;
      mb_q <= 1'b0;
      fresh_q <= 1'b0;
      drive_q <= 1'b0;
      rd_sample_q <= 1'b0;
      pend_q <= 1'b0;
      int_q <= 1'b0;
      pend_data_q <= 48'd0;
      regs_q <= '{default: 8'h00};
    end else begin
      sclk_q <= {sclk_q[SYNC_STAGES-1:0], spi_sclk};
      cs_q <= {cs_q[SYNC_STAGES-1:0], spi_cs_n};
      sdat_q <= {sdat_q[SYNC_STAGES-1:0], spi_sdat_i};
      // a CS_N fall seen while this mask drains means CS_N was already low at reset release
      start_q <= start_q >> 1;
      state_q <= state_d;
      int_q <= (|(regs_q[6'h30] & regs_q[6'h2E])) ^ regs_q[6'h31][5];
      if (sclk_rise) begin
        rx_q <= rx_byte[6:0];
        bit_cnt_q <= bit_cnt_q + 3'd1;
      end
      if (state_q == IDLE) begin
        bit_cnt_q <= 3'd0;
        rd_sample_q <= 1'b0;
        drive_q <= 1'b0;
      end
      if (state_q == CMD && byte_done) begin
        addr_q <= rx_byte[5:0];
        mb_q <= rx_byte[6];
        sout_q <= rd_reg(rx_byte[5:0]);
        fresh_q <= 1'b1;
      end
      if (state_q == RDATA && sclk_fall) begin
        drive_q <= 1'b1;
        fresh_q <= 1'b0;
        if (!fresh_q) sout_q <= {sout_q[6:0], 1'b0};
      end
      if (state_q == RDATA && byte_done) begin
        if (is_sample(addr_q)) rd_sample_q <= 1'b1;
        addr_q <= addr_nxt;
        sout_q <= rd_reg(addr_nxt);
        fresh_q <= 1'b1;
      end
      if (state_q == WDATA && byte_done) begin
        addr_q <= addr_nxt;
        if (writable(addr_q)) regs_q[addr_q] <= rx_byte;
      end
      if (cs_rise && rd_sample_q) regs_q[6'h30][7] <= 1'b0;
      if (in_frame && sample_valid) begin
        pend_q <= 1'b1;
        pend_data_q <= {sample_z, sample_y, sample_x};
      end
      // placed after the DATA_READY clear so that a commit in the same cycle wins
      if (smp_wr) begin
        pend_q <= 1'b0;
        regs_q[6'h32] <= smp[7:0];
        regs_q[6'h33] <= smp[15:8];
        regs_q[6'h34] <= smp[23:16];
        regs_q[6'h35] <= smp[31:24];
        regs_q[6'h36] <= smp[39:32];
        regs_q[6'h37] <= smp[47:40];
        regs_q[6'h30][7] <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_nios_accel_spi_responder.sv
// tb_nios_accel_spi_responder: directed SPI frames against the responder with hand-computed expectations.
module tb_nios_accel_spi_responder;
  logic clk_clk = 1'b0;
  logic reset_reset = 1'b1;
  logic spi_sclk = 1'b1;
  logic spi_cs_n = 1'b1;
  logic spi_sdat_i = 1'b0;
  logic spi_sdat_o, spi_sdat_oe, spi_int;
  logic [15:0] sample_x = 16'h0, sample_y = 16'h0, sample_z = 16'h0;
  logic sample_valid = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [7:0] rxb [8];
  logic oeb [8];
  logic [7:0] r;
  logic o;

  nios_accel_spi_responder dut (
    .clk_clk(clk_clk),
    .reset_reset(reset_reset),
    .spi_sclk(spi_sclk),
    .spi_cs_n(spi_cs_n),
    .spi_sdat_i(spi_sdat_i),
    .spi_sdat_o(spi_sdat_o),
    .spi_sdat_oe(spi_sdat_oe),
    .spi_int(spi_int),
    .sample_x(sample_x),
    .sample_y(sample_y),
    .sample_z(sample_z),
    .sample_valid(sample_valid)
  );

  always #5 clk_clk = ~clk_clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // master drives on SCLK fall, samples responder data just before the rise
  task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx, output logic oe_any);
    rx = 8'h00;
    oe_any = 1'b0;
    for (int i = 7; i >= 8 - nbits; i--) begin
      spi_sclk = 1'b0;
      spi_sdat_i = tx[i];
      #40;
      rx[i] = spi_sdat_o;
      oe_any = oe_any | spi_sdat_oe;
      spi_sclk = 1'b1;
      #40;
    end
  endtask

  task automatic cs_begin();
    spi_cs_n = 1'b0;
    #80;
  endtask

  task automatic cs_end();
    #40;
    spi_cs_n = 1'b1;
    #80;
  endtask

  task automatic wr(input logic [5:0] a, input logic [7:0] d);
    logic [7:0] rr;
    logic oo;
    cs_begin();
    xfer({2'b00, a}, 8, rr, oo);
    xfer(d, 8, rr, oo);
    cs_end();
  endtask

  task automatic rd(input logic [7:0] cmd, input int n);
    logic [7:0] rr;
    logic oo;
    cs_begin();
    xfer(cmd, 8, rr, oo);
    for (int k = 0; k < n; k++) begin
      xfer(8'h00, 8, rr, oo);
      rxb[k] = rr;
      oeb[k] = oo;
    end
    cs_end();
  endtask

  task automatic pulse(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    @(negedge clk_clk);
    sample_x = x;
    sample_y = y;
    sample_z = z;
    sample_valid = 1'b1;
    @(negedge clk_clk);
    sample_valid = 1'b0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (5) @(negedge clk_clk);
    check("rst_oe", {15'd0, spi_sdat_oe}, 16'd0);
    check("rst_sdo", {15'd0, spi_sdat_o}, 16'd0);
    check("rst_int", {15'd0, spi_int}, 16'd0);
    reset_reset = 1'b0;
    repeat (10) @(negedge clk_clk);

    rd(8'h80, 1);
    check("devid", {8'd0, rxb[0]}, 16'h00E5);
    check("devid_oe", {15'd0, oeb[0]}, 16'd1);
    check("oe_after_cs", {15'd0, spi_sdat_oe}, 16'd0);
    rd(8'h90, 1);
    check("reg10_rst", {8'd0, rxb[0]}, 16'h0000);

    wr(6'h2E, 8'h80);
    wr(6'h31, 8'h00);
    rd(8'hAE, 1);
    check("int_en_rb", {8'd0, rxb[0]}, 16'h0080);
    check("int_idle", {15'd0, spi_int}, 16'd0);
    pulse(16'h0123, 16'h4567, 16'h89AB);
    repeat (5) @(negedge clk_clk);
    check("int_set", {15'd0, spi_int}, 16'd1);
    rd(8'hB0, 1);
    check("int_src", {8'd0, rxb[0]}, 16'h0080);
    check("int_hold", {15'd0, spi_int}, 16'd1);
    rd(8'hF2, 6);
    check("smp0", {8'd0, rxb[0]}, 16'h0023);
    check("smp1", {8'd0, rxb[1]}, 16'h0001);
    check("smp2", {8'd0, rxb[2]}, 16'h0067);
    check("smp3", {8'd0, rxb[3]}, 16'h0045);
    check("smp4", {8'd0, rxb[4]}, 16'h00AB);
    check("smp5", {8'd0, rxb[5]}, 16'h0089);
    check("int_clr", {15'd0, spi_int}, 16'd0);

    cs_begin();
    xfer(8'hF2, 8, r, o);
    xfer(8'h00, 8, r, o);
    check("pend_b0", {8'd0, r}, 16'h0023);
    pulse(16'h1111, 16'h0000, 16'h0000);
    xfer(8'h00, 8, r, o);
    check("pend_b1", {8'd0, r}, 16'h0001);
    pulse(16'h2222, 16'h3333, 16'h4444);
    xfer(8'h00, 8, r, o);
    check("pend_b2", {8'd0, r}, 16'h0067);
    cs_end();
    rd(8'hB0, 1);
    check("dr_reset", {8'd0, rxb[0]}, 16'h0080);
    rd(8'hF2, 6);
    check("new0", {8'd0, rxb[0]}, 16'h0022);
    check("new1", {8'd0, rxb[1]}, 16'h0022);
    check("new3", {8'd0, rxb[3]}, 16'h0033);
    check("new5", {8'd0, rxb[5]}, 16'h0044);

    wr(6'h31, 8'h20);
    repeat (3) @(negedge clk_clk);
    check("int_inv", {15'd0, spi_int}, 16'd1);
    wr(6'h31, 8'h00);
    repeat (3) @(negedge clk_clk);
    check("int_noinv", {15'd0, spi_int}, 16'd0);

    wr(6'h3F, 8'hA7);
    rd(8'hFF, 2);
    check("wrap0", {8'd0, rxb[0]}, 16'h00A7);
    check("wrap1", {8'd0, rxb[1]}, 16'h00E5);

    wr(6'h1E, 8'h3C);
    cs_begin();
    xfer(8'h1E, 8, r, o);
    xfer(8'hAA, 5, r, o);
    cs_end();
    rd(8'h9E, 1);
    check("partial", {8'd0, rxb[0]}, 16'h003C);
    wr(6'h00, 8'h55);
    rd(8'h80, 1);
    check("devid_ro", {8'd0, rxb[0]}, 16'h00E5);
    wr(6'h32, 8'h99);
    rd(8'hB2, 1);
    check("smp_ro", {8'd0, rxb[0]}, 16'h0022);

    cs_begin();
    xfer(8'h05, 8, r, o);
    xfer(8'h11, 8, r, o);
    xfer(8'h99, 8, r, o);
    cs_end();
    rd(8'h85, 2);
    check("mb0_wr", {8'd0, rxb[0]}, 16'h0011);
    check("mb0_oe", {15'd0, oeb[1]}, 16'd0);
    check("mb0_sdo", {8'd0, rxb[1]}, 16'h0000);

    cs_begin();
    xfer(8'h47, 8, r, o);
    xfer(8'hA1, 8, r, o);
    xfer(8'hB2, 8, r, o);
    cs_end();
    rd(8'hC7, 2);
    check("mbw0", {8'd0, rxb[0]}, 16'h00A1);
    check("mbw1", {8'd0, rxb[1]}, 16'h00B2);

    cs_begin();
    xfer(8'h1E, 8, r, o);
    @(negedge clk_clk);
    reset_reset = 1'b1;
    repeat (3) @(negedge clk_clk);
    check("rst_mid_oe", {15'd0, spi_sdat_oe}, 16'd0);
    reset_reset = 1'b0;
    repeat (4) @(negedge clk_clk);
    xfer(8'h1E, 8, r, o);
    xfer(8'hFF, 8, r, o);
    xfer(8'h9E, 8, r, o);
    xfer(8'h00, 8, r, o);
    check("ign_oe", {15'd0, o}, 16'd0);
    cs_end();
    rd(8'h9E, 1);
    check("ign_nowr", {8'd0, rxb[0]}, 16'h0000);
    rd(8'h80, 1);
    check("post_rst", {8'd0, rxb[0]}, 16'h00E5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
